ifetch_queue: RTL and testbench

Instruction fetch unit for the next OpenMIPS revision. It replaces the bare pc_reg plus combinational ROM port with a pipelined request/grant/response memory interface and a small prefetch queue. It sits upstream of if_id, generating fetch addresses toward instruction memory. It delivers {pc, inst} pairs to decode through a valid/ready handshake, and supports a branch/redirect flush.

---
 rtl/ifetch_queue_pkg.sv | 22 ++
 rtl/ifetch_queue_fifo.sv | 54 +++++
 rtl/ifetch_queue.sv | 110 +++++++++++
 tb/tb_ifetch_queue.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifetch_queue_pkg;

  localparam int              INST_ADDR_W       = 32;
  localparam int              INST_W            = 32;
  localparam logic            RST_ENABLE_N      = 1'b0;
  localparam int              IFQ_DEPTH_DEFAULT = 4;
  localparam logic [31:0]     INST_ALIGN_MASK   = 32'hFFFF_FFFC;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } ifq_entry_t;

  function automatic inst_addr_t align_pc(input inst_addr_t a);
    return a & INST_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// First-word-fall-through FIFO holding {pc, inst} pairs; clear has priority
// over push and pop.
module ifq_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH_DEFAULT,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  input  logic                       i_clear,
  output logic                       o_empty,
  output logic [W-1:0]               o_data,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_cnt;
  logic          w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE_N) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // Storage needs no reset; the top masks the head while empty.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: credit-limited request/grant/response fetch into a
// small prefetch queue, with redirect flush that drops in-flight responses.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = IFQ_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  input  logic        inst_ready_i
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  logic          r_live;
  inst_addr_t    r_fetch_pc;
  inst_addr_t    r_resp_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;

  logic          w_empty;
  ifq_entry_t    w_head;
  ifq_entry_t    w_push_entry;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_credit;
  logic          w_gnt;
  logic          w_rv;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_out_dec;
  logic [CW-1:0] w_drop_dec;

  assign w_credit  = {1'b0, w_count} + {1'b0, r_out};
  assign mem_req_o = r_live && !flush_i && (w_credit < DEPTH_W);
  assign mem_addr_o = r_fetch_pc;

  assign w_gnt  = mem_req_o && mem_gnt_i;
  assign w_rv   = mem_rvalid_i && (r_out != '0);
  assign w_drop = w_rv && (r_drop != '0);
  assign w_push = w_rv && !w_drop && !flush_i;
  assign w_pop  = inst_valid_o && inst_ready_i && !flush_i;

  assign w_out_dec  = r_out  - CW'(w_rv);
  assign w_drop_dec = r_drop - CW'(w_drop);

  assign w_push_entry = '{pc: r_resp_pc, inst: mem_rdata_i};

  assign inst_valid_o = !w_empty;
  assign inst_o       = w_empty ? '0 : w_head.inst;
  assign pc_o         = w_empty ? '0 : w_head.pc;

  ifq_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(ifq_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_clear (flush_i),
    .o_empty (w_empty),
    .o_data  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE_N) begin
      r_live     <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out      <= '0;
      r_drop     <= '0;
    end else begin
      r_live <= 1'b1;
      if (flush_i) begin
        r_fetch_pc <= align_pc(flush_pc_i);
        r_resp_pc  <= align_pc(flush_pc_i);
        r_out      <= w_out_dec;
        // r_out counts every request in flight, stale or live, so after a
        // redirect every remaining response is stale.
        r_drop     <= w_out_dec;
      end else begin
        if (w_gnt)  r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push) r_resp_pc  <= r_resp_pc + 32'd4;
        r_out  <= w_out_dec + CW'(w_gnt);
        r_drop <= w_drop_dec;
      end
    end
  end

  a_credit : assert property (@(posedge clk) disable iff (rst == RST_ENABLE_N)
    w_credit <= DEPTH_W);
  a_drop : assert property (@(posedge clk) disable iff (rst == RST_ENABLE_N)
    r_drop <= r_out);

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: memory responder, fetch-address model and a
// delivery scoreboard checked by a monitor on the falling clock edge.
module tb_ifetch_queue;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_ready_i;

  ifetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .inst_ready_i (inst_ready_i)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          nchk = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_gnt = 0;
  int          n_deliv = 0;
  logic        spur = 1'b0;
  logic [31:0] exp_fetch = 32'h0;
  logic [63:0] exp_q[$];
  pend_t       pend[$];
  logic [31:0] dlog[$];
  logic [31:0] glog[$];

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C1D_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_deliv(input int target, input int budget, input string nm);
    int k = 0;
    while (n_deliv < target && k < budget) begin
      tick(1);
      k++;
    end
    nchk++;
    if (n_deliv < target) begin
      nerr++;
      $display("FAIL %s: deliveries %0d, expected %0d", nm, n_deliv, target);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'h0, mem_req_o},    32'h0);
    chk({tag, "_addr"},  mem_addr_o,            32'h0);
    chk({tag, "_valid"}, {31'h0, inst_valid_o}, 32'h0);
    chk({tag, "_inst"},  inst_o,                32'h0);
    chk({tag, "_pc"},    pc_o,                  32'h0);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: in-order responses 'lat' cycles after grant.
  initial begin
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst) begin
        mem_rvalid_i = 1'b0;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rom(pend[0].addr);
        void'(pend.pop_front());
      end else if (spur) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0_BAD0;
        spur = 1'b0;
      end else begin
        mem_rvalid_i = 1'b0;
      end
    end
  end

  // Monitor: sees the handshakes that the next rising edge will commit.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        pend.delete();
        exp_fetch = 32'h0;
      end else if (flush_i) begin
        chk("req_in_flush", {31'h0, mem_req_o}, 32'h0);
        exp_q.delete();
        exp_fetch = flush_pc_i & 32'hFFFF_FFFC;
      end else begin
        if (inst_valid_o && inst_ready_i) begin
          n_deliv++;
          dlog.push_back(pc_o);
          if (exp_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_deliv: got pc %h, expected none", pc_o);
          end else begin
            e = exp_q.pop_front();
            chk("deliv_pc",   pc_o,   e[63:32]);
            chk("deliv_inst", inst_o, e[31:0]);
          end
        end
        if (mem_req_o && mem_gnt_i) begin
          n_gnt++;
          chk("gnt_addr", mem_addr_o, exp_fetch);
          glog.push_back(mem_addr_o);
          exp_q.push_back({exp_fetch, rom(exp_fetch)});
          pend.push_back('{addr: mem_addr_o, due: cyc + lat});
          exp_fetch = exp_fetch + 32'd4;
        end
      end
    end
  end

  initial begin
    int g0;
    int d0;
    rst          = 1'b0;
    flush_i      = 1'b0;
    flush_pc_i   = 32'h0;
    mem_gnt_i    = 1'b0;
    inst_ready_i = 1'b0;
    tick(3);
    chk_reset_outputs("reset");

    // Streaming: addresses and delivered pcs count up from 0.
    rst = 1'b1;
    mem_gnt_i = 1'b1;
    inst_ready_i = 1'b1;
    lat = 1;
    dlog.delete();
    wait_deliv(8, 100, "stream_wait");
    for (int i = 0; i < 8; i++)
      if (i < dlog.size()) chk("stream_pc", dlog[i], 32'(i * 4));
    mem_gnt_i = 1'b0;
    tick(10);
    chk("stream_drained", 32'(exp_q.size()), 32'h0);

    // Credit limit with decode stalled.
    inst_ready_i = 1'b0;
    mem_gnt_i = 1'b1;
    flush_i = 1'b1;
    flush_pc_i = 32'h0;
    tick(1);
    flush_i = 1'b0;
    g0 = n_gnt;
    d0 = n_deliv;
    tick(12);
    chk("credit_grants", 32'(n_gnt - g0), 32'd4);
    chk("credit_req", {31'h0, mem_req_o}, 32'h0);
    chk("credit_addr", mem_addr_o, 32'h10);
    chk("credit_valid", {31'h0, inst_valid_o}, 32'h1);
    chk("credit_head_pc", pc_o, 32'h0);
    chk("credit_head_inst", inst_o, rom(32'h0));
    inst_ready_i = 1'b1;
    tick(1);
    inst_ready_i = 1'b0;
    tick(5);
    chk("credit_one_more", 32'(n_gnt - g0), 32'd5);
    chk("credit_addr2", mem_addr_o, 32'h14);
    chk("credit_deliv", 32'(n_deliv - d0), 32'd1);

    // Grant withheld: request and address hold.
    mem_gnt_i = 1'b0;
    inst_ready_i = 1'b1;
    tick(10);
    chk("drain_sb", 32'(exp_q.size()), 32'h0);
    inst_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("hold_req", {31'h0, mem_req_o}, 32'h1);
      chk("hold_addr", mem_addr_o, 32'h14);
    end
    g0 = n_gnt;
    mem_gnt_i = 1'b1;
    tick(1);
    mem_gnt_i = 1'b0;
    tick(3);
    chk("hold_one_grant", 32'(n_gnt - g0), 32'd1);
    chk("hold_next_addr", mem_addr_o, 32'h18);

    // Flush with three requests in flight and a word waiting in the queue.
    lat = 4;
    chk("pre_flush_pc", pc_o, 32'h14);
    mem_gnt_i = 1'b1;
    tick(3);
    mem_gnt_i = 1'b0;
    dlog.delete();
    flush_i = 1'b1;
    flush_pc_i = 32'h0000_1003;
    tick(1);
    flush_i = 1'b0;
    chk("post_flush_valid", {31'h0, inst_valid_o}, 32'h0);
    inst_ready_i = 1'b1;
    mem_gnt_i = 1'b1;
    d0 = n_deliv;
    wait_deliv(d0 + 4, 200, "flush_wait");
    if (dlog.size() > 0) chk("flush_first_pc", dlog[0], 32'h1000);
    mem_gnt_i = 1'b0;
    tick(20);
    chk("flush_drained", 32'(exp_q.size()), 32'h0);

    // Response with no request outstanding is ignored.
    spur = 1'b1;
    tick(4);
    chk("spur_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("spur_req", {31'h0, mem_req_o}, 32'h1);

    // Flush coinciding with a response, then a second flush right after.
    lat = 1;
    mem_gnt_i = 1'b1;
    tick(6);
    dlog.delete();
    flush_i = 1'b1;
    flush_pc_i = 32'h200;
    tick(1);
    flush_pc_i = 32'h300;
    tick(1);
    flush_i = 1'b0;
    d0 = n_deliv;
    wait_deliv(d0 + 3, 100, "b2b_wait");
    if (dlog.size() > 0) chk("b2b_first_pc", dlog[0], 32'h300);
    mem_gnt_i = 1'b0;
    tick(10);
    chk("b2b_drained", 32'(exp_q.size()), 32'h0);

    // Address wrap, then asynchronous reset mid-stream.
    mem_gnt_i = 1'b1;
    flush_i = 1'b1;
    flush_pc_i = 32'hFFFF_FFF8;
    tick(1);
    glog.delete();
    flush_i = 1'b0;
    tick(3);
    chk("wrap_count_ok", {31'h0, glog.size() >= 3}, 32'h1);
    if (glog.size() >= 3) begin
      chk("wrap_a0", glog[0], 32'hFFFF_FFF8);
      chk("wrap_a1", glog[1], 32'hFFFF_FFFC);
      chk("wrap_a2", glog[2], 32'h0000_0000);
    end
    tick(2);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    tick(2);
    glog.delete();
    rst = 1'b1;
    tick(3);
    chk("post_rst_any_grant", {31'h0, glog.size() > 0}, 32'h1);
    if (glog.size() > 0) chk("post_rst_addr", glog[0], 32'h0);
    mem_gnt_i = 1'b0;
    tick(10);
    chk("final_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
